// File: rtl/lsm_sequencer_if.sv
// Handshake bundle between the control unit and the LSM sequencer.
// The CU drives IR/LOAD/NEXT; the sequencer returns list-walk status.
interface lsm_sequencer_if #(
   parameter int OFS_W = 8
);
   logic [31:0]      IR;
   logic             LOAD;
   logic             NEXT;
   logic             LSM_DETECT;
   logic             LSM_END;
   logic             BUSY;
   logic [3:0]       REG_NUM;
   logic [OFS_W-1:0] OFFSET;
   logic [OFS_W-1:0] WB_OFFSET;
   logic [4:0]       COUNT;

   modport master (
      output IR, LOAD, NEXT,
      input  LSM_DETECT, LSM_END, BUSY,
      input  REG_NUM, OFFSET, WB_OFFSET, COUNT
   );

   modport slave (
      input  IR, LOAD, NEXT,
      output LSM_DETECT, LSM_END, BUSY,
      output REG_NUM, OFFSET, WB_OFFSET, COUNT
   );
endinterface

// File: rtl/lsm_sequencer.sv
// LDM/STM register-list sequencer: walks the list lowest-first and
// supplies register number, byte offset and write-back delta to the CU.
module lsm_sequencer #(
   parameter int WORD_BYTES = 4,
   parameter int OFS_W      = 8
) (
   input logic            CLK,
   input logic            RESET,
   lsm_sequencer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

   state_t      state_q, state_d;
   logic [15:0] list_q, list_d;
   logic        p_q, p_d;
   logic        u_q, u_d;
   logic        vld_q, vld_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [4:0]  step_q, step_d;

   logic [3:0]       reg_num;
   logic [OFS_W-1:0] n4, s4, start, wb;

   function automatic logic [4:0] popcnt(input logic [15:0] v);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
      return c;
   endfunction

   // State and latched instruction fields
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         list_q  <= '0;
         p_q     <= 1'b0;
         u_q     <= 1'b0;
         vld_q   <= 1'b0;
         cnt_q   <= '0;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         list_q  <= list_d;
         p_q     <= p_d;
         u_q     <= u_d;
         vld_q   <= vld_d;
         cnt_q   <= cnt_d;
         step_q  <= step_d;
      end
   end

   // Next-state: LOAD only acts in IDLE, NEXT only acts in ACTIVE
   always_comb begin
      state_d = state_q;
      list_d  = list_q;
      p_d     = p_q;
      u_d     = u_q;
      vld_d   = vld_q;
      cnt_d   = cnt_q;
      step_d  = step_q;
      unique case (state_q)
         IDLE: begin
            if (bus.LOAD) begin
               list_d  = bus.IR[15:0];
               p_d     = bus.IR[24];
               u_d     = bus.IR[23];
               vld_d   = 1'b1;
               cnt_d   = popcnt(bus.IR[15:0]);
               step_d  = '0;
               state_d = (bus.IR[15:0] != '0) ? ACTIVE : DONE;
            end
         end
         ACTIVE: begin
            if (bus.NEXT) begin
               list_d = list_q & (list_q - 16'd1);
               step_d = step_q + 5'd1;
               if (list_d == '0) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Lowest remaining list bit is the current register
   always_comb begin
      reg_num = '0;
      for (int i = 15; i >= 0; i--) begin
         if (list_q[i]) reg_num = 4'(i);
      end
   end

   // Addressing-mode offsets in OFS_W two's complement
   always_comb begin
      n4 = OFS_W'(cnt_q) * OFS_W'(WORD_BYTES);
      s4 = OFS_W'(step_q) * OFS_W'(WORD_BYTES);
      unique case ({p_q, u_q})
         2'b01:   start = '0;
         2'b11:   start = OFS_W'(WORD_BYTES);
         2'b00:   start = OFS_W'(WORD_BYTES) - n4;
         default: start = '0 - n4;
      endcase
      wb = u_q ? n4 : ('0 - n4);
   end

   assign bus.LSM_DETECT = (bus.IR[27:25] == 3'b100);
   assign bus.LSM_END    = (state_q == DONE);
   assign bus.BUSY       = (state_q == ACTIVE);
   assign bus.REG_NUM    = reg_num;
   assign bus.COUNT      = cnt_q;
   assign bus.OFFSET     = vld_q ? (start + s4) : '0;
   assign bus.WB_OFFSET  = vld_q ? wb : '0;

endmodule

// File: tb/tb_lsm_sequencer.sv
// Bench for lsm_sequencer: vector table with a transfer scoreboard,
// plus hand sequences for reset, LOAD/NEXT collisions and holds.
module tb_lsm_sequencer;

   logic CLK = 1'b0;
   logic RESET;

   lsm_sequencer_if #(.OFS_W(8)) bus ();

   lsm_sequencer #(.WORD_BYTES(4), .OFS_W(8)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus.slave)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] ir;
      int          cnt;
      int          wb;
      int          ofs0;
   } vec_t;

   typedef struct {
      int rn;
      int ofs;
   } xfer_t;

   vec_t  vt [7];
   xfer_t sb [$];
   int    checks = 0;
   int    errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int sofs();
      return int'($signed(bus.OFFSET));
   endfunction

   function automatic int swb();
      return int'($signed(bus.WB_OFFSET));
   endfunction

   task automatic run_vec(input vec_t v);
      xfer_t x;
      int    k;
      k = 0;
      for (int i = 0; i < 16; i++) begin
         if (v.ir[i]) begin
            x.rn  = i;
            x.ofs = v.ofs0 + 4 * k;
            sb.push_back(x);
            k++;
         end
      end
      bus.IR   = v.ir;
      bus.LOAD = 1'b1;
      @(negedge CLK);
      bus.LOAD = 1'b0;
      chk("detect", int'(bus.LSM_DETECT), 1);
      chk("count", int'(bus.COUNT), v.cnt);
      chk("wb", swb(), v.wb);
      if (sb.size() == 0) begin
         chk("empty_busy", int'(bus.BUSY), 0);
      end
      while (sb.size() > 0) begin
         x = sb.pop_front();
         chk("busy", int'(bus.BUSY), 1);
         chk("end_early", int'(bus.LSM_END), 0);
         chk("reg_num", int'(bus.REG_NUM), x.rn);
         chk("offset", sofs(), x.ofs);
         chk("wb_hold", swb(), v.wb);
         bus.NEXT = 1'b1;
         @(negedge CLK);
         bus.NEXT = 1'b0;
      end
      chk("end_pulse", int'(bus.LSM_END), 1);
      chk("done_busy", int'(bus.BUSY), 0);
      @(negedge CLK);
      chk("end_once", int'(bus.LSM_END), 0);
      chk("idle_busy", int'(bus.BUSY), 0);
   endtask

   initial begin
      vt[0] = '{32'hE890_8005,  3,  12,   0};
      vt[1] = '{32'hE910_0003,  2,  -8,  -8};
      vt[2] = '{32'hE980_0001,  1,   4,   4};
      vt[3] = '{32'hE800_0001,  1,  -4,   0};
      vt[4] = '{32'hE890_0000,  0,   0,   0};
      vt[5] = '{32'hE8BD_8000,  1,   4,   0};
      vt[6] = '{32'hE810_00F0,  4, -16, -12};

      RESET    = 1'b1;
      bus.IR   = 32'hE8BD_8000;
      bus.LOAD = 1'b0;
      bus.NEXT = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      chk("rst_detect", int'(bus.LSM_DETECT), 1);
      chk("rst_busy", int'(bus.BUSY), 0);
      chk("rst_end", int'(bus.LSM_END), 0);
      chk("rst_reg", int'(bus.REG_NUM), 0);
      chk("rst_ofs", sofs(), 0);
      chk("rst_wb", swb(), 0);
      chk("rst_count", int'(bus.COUNT), 0);
      bus.IR = 32'h1AFF_FFFD;
      #1;
      chk("branch_detect", int'(bus.LSM_DETECT), 0);
      @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);

      for (int i = 0; i < 7; i++) run_vec(vt[i]);

      // LOAD and NEXT together in IDLE: LOAD wins, step starts at 0
      bus.IR   = 32'hE890_8005;
      bus.LOAD = 1'b1;
      bus.NEXT = 1'b1;
      @(negedge CLK);
      bus.NEXT = 1'b0;
      chk("ln_busy", int'(bus.BUSY), 1);
      chk("ln_reg", int'(bus.REG_NUM), 0);
      chk("ln_ofs", sofs(), 0);
      // LOAD mid-ACTIVE with a different IR is ignored; outputs hold
      bus.IR = 32'hE910_0003;
      @(negedge CLK);
      bus.LOAD = 1'b0;
      @(negedge CLK);
      chk("hold_reg", int'(bus.REG_NUM), 0);
      chk("hold_ofs", sofs(), 0);
      chk("hold_count", int'(bus.COUNT), 3);
      chk("hold_wb", swb(), 12);
      bus.NEXT = 1'b1;
      @(negedge CLK);
      chk("mid_reg", int'(bus.REG_NUM), 2);
      chk("mid_ofs", sofs(), 4);
      @(negedge CLK);
      chk("last_reg", int'(bus.REG_NUM), 15);
      chk("last_ofs", sofs(), 8);
      @(negedge CLK);
      bus.NEXT = 1'b0;
      chk("ln_end", int'(bus.LSM_END), 1);
      @(negedge CLK);
      chk("ln_end_once", int'(bus.LSM_END), 0);

      // Reset in the middle of a full-list walk
      bus.IR   = 32'hE890_FFFF;
      bus.LOAD = 1'b1;
      @(negedge CLK);
      bus.LOAD = 1'b0;
      chk("full_count", int'(bus.COUNT), 16);
      chk("full_wb", swb(), 64);
      bus.NEXT = 1'b1;
      repeat (5) @(negedge CLK);
      bus.NEXT = 1'b0;
      chk("full_reg5", int'(bus.REG_NUM), 5);
      chk("full_ofs5", sofs(), 20);
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      chk("mr_busy", int'(bus.BUSY), 0);
      chk("mr_end", int'(bus.LSM_END), 0);
      chk("mr_reg", int'(bus.REG_NUM), 0);
      chk("mr_ofs", sofs(), 0);
      chk("mr_wb", swb(), 0);
      chk("mr_count", int'(bus.COUNT), 0);
      bus.NEXT = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge CLK);
         chk("nx_busy", int'(bus.BUSY), 0);
         chk("nx_end", int'(bus.LSM_END), 0);
      end
      bus.NEXT = 1'b0;
      chk("nx_count", int'(bus.COUNT), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
